// File: rtl/ddr_cmd_sequencer_if.sv
// Requester/command bus between the requesters and the DDR4 command sequencer.
//   master: drives requests (valid/we/bg/ba/row), observes ack and the command stream
//   slave : the sequencer; consumes requests, drives ack, command pulse, address, status
interface ddr_cmd_sequencer_if #(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned BGWIDTH  = 2,
   parameter int unsigned BAWIDTH  = 2,
   parameter int unsigned ROWWIDTH = 16
);
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_we;
   logic [NREQ*BGWIDTH-1:0]  req_bg;
   logic [NREQ*BAWIDTH-1:0]  req_ba;
   logic [NREQ*ROWWIDTH-1:0] req_row;
   logic [NREQ-1:0]          req_ack;
   logic [18:0]              commands;
   logic [BGWIDTH-1:0]       bg;
   logic [BAWIDTH-1:0]       ba;
   logic [ROWWIDTH-1:0]      row;
   logic                     busy;
   logic                     ref_overrun;

   modport master (
      output req_valid, req_we, req_bg, req_ba, req_row,
      input  req_ack, commands, bg, ba, row, busy, ref_overrun
   );

   modport slave (
      input  req_valid, req_we, req_bg, req_ba, req_row,
      output req_ack, commands, bg, ba, row, busy, ref_overrun
   );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: round-robin arbitration over NREQ requesters, open-page
// tracking per bank, PR/ACT/RD/WR sequencing with fixed spacing, and periodic
// all-bank refresh (PRA + REF) every T_REFI cycles.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : req_valid/we/bg/ba/row in, req_ack out, one-hot commands
//                  ([18]ACT [7]PR [6]PRA [5]RD [3]REF [1]WR), bg/ba/row, busy, ref_overrun
module ddr_cmd_sequencer #(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned BL       = 8,
   parameter int unsigned BGWIDTH  = 2,
   parameter int unsigned BAWIDTH  = 2,
   parameter int unsigned ROWWIDTH = 16,
   parameter int unsigned T_RCD    = 17,
   parameter int unsigned T_RP     = 17,
   parameter int unsigned T_RAS    = 32,
   parameter int unsigned T_RFC    = 34,
   parameter int unsigned T_WR     = 14,
   parameter int unsigned T_CWL    = 10,
   parameter int unsigned T_CCD    = 4,
   parameter int unsigned T_REFI   = 9360
) (
   input logic                clk,
   input logic                reset_n,
   ddr_cmd_sequencer_if.slave bus
);
   localparam int unsigned GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NBW   = BGWIDTH + BAWIDTH;
   localparam int unsigned NBANK = 1 << NBW;

   // Wait loads are "cycles until next command" minus one: the command issued
   // from WAIT is registered, so it lands exactly T cycles after the previous one.
   localparam logic [7:0]  W_RP      = 8'(T_RP - 1);
   localparam logic [7:0]  W_RCD     = 8'(T_RCD - 1);
   localparam logic [7:0]  W_RFC     = 8'(T_RFC - 1);
   localparam logic [7:0]  W_CCD     = 8'(T_CCD - 1);
   localparam logic [7:0]  W_WREC    = 8'(T_CWL + BL / 2 + T_WR - 1);
   localparam logic [7:0]  RAS_LOAD  = 8'(T_RAS - 1);
   localparam logic [15:0] REFI_LOAD = 16'(T_REFI - 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_WAIT} state_t;
   typedef enum logic [2:0] {I_NONE, I_PR, I_ACT, I_RW, I_PRA, I_REF} issue_t;

   state_t              state_q, state_d, ret_q, ret_d;
   logic [7:0]          wait_cnt_q, wait_cnt_d, ras_cnt_q, ras_cnt_d;
   logic [15:0]         refi_cnt_q, refi_cnt_d;
   logic                ref_pend_q, ref_pend_d, ref_overrun_q, ref_overrun_d;
   logic [GW-1:0]       rr_last_q, rr_last_d, grant_q, grant_d;
   logic                lat_we_q, lat_we_d;
   logic [BGWIDTH-1:0]  lat_bg_q, lat_bg_d, bg_q, bg_d;
   logic [BAWIDTH-1:0]  lat_ba_q, lat_ba_d, ba_q, ba_d;
   logic [ROWWIDTH-1:0] lat_row_q, lat_row_d, row_q, row_d;
   logic [NBANK-1:0]    open_q, open_d;
   logic [ROWWIDTH-1:0] open_row_q [NBANK];
   logic [ROWWIDTH-1:0] open_row_d [NBANK];
   logic [18:0]         commands_q, commands_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic                busy_q, busy_d;
   issue_t              issue;
   logic [NBW-1:0]      bidx;
   logic                ras_ok;
   logic                found;
   int unsigned         cand;

   assign ras_ok = (ras_cnt_q == 8'd0);
   assign bidx   = {lat_bg_d, lat_ba_d};

   // Next-state: decide what to issue this cycle, then apply the issue uniformly.
   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      wait_cnt_d    = (wait_cnt_q != 8'd0) ? wait_cnt_q - 8'd1 : wait_cnt_q;
      ras_cnt_d     = ras_ok ? ras_cnt_q : ras_cnt_q - 8'd1;
      refi_cnt_d    = (refi_cnt_q == 16'd0) ? REFI_LOAD : refi_cnt_q - 16'd1;
      ref_pend_d    = ref_pend_q;
      ref_overrun_d = ref_overrun_q;
      rr_last_d     = rr_last_q;
      grant_d       = grant_q;
      lat_we_d      = lat_we_q;
      lat_bg_d      = lat_bg_q;
      lat_ba_d      = lat_ba_q;
      lat_row_d     = lat_row_q;
      open_d        = open_q;
      open_row_d    = open_row_q;
      commands_d    = '0;
      ack_d         = '0;
      bg_d          = bg_q;
      ba_d          = ba_q;
      row_d         = row_q;
      issue         = I_NONE;
      found         = 1'b0;
      cand          = 0;

      case (state_q)
         S_IDLE: begin
            if (ref_pend_q) begin
               if (|open_q) begin
                  if (ras_ok) issue = I_PRA;
                  else        state_d = S_PREA;
               end else begin
                  issue = I_REF;
               end
            end else begin
               // Round-robin: first valid requester after the last winner.
               for (int unsigned i = 1; i <= NREQ; i++) begin
                  cand = (int'(rr_last_q) + i) % NREQ;
                  if (!found && bus.req_valid[cand]) begin
                     found     = 1'b1;
                     grant_d   = GW'(cand);
                     lat_we_d  = bus.req_we[cand];
                     lat_bg_d  = bus.req_bg[cand*BGWIDTH +: BGWIDTH];
                     lat_ba_d  = bus.req_ba[cand*BAWIDTH +: BAWIDTH];
                     lat_row_d = bus.req_row[cand*ROWWIDTH +: ROWWIDTH];
                  end
               end
               if (found) begin
                  rr_last_d = grant_d;
                  if (!open_q[bidx])                      issue = I_ACT;
                  else if (open_row_q[bidx] == lat_row_d) issue = I_RW;
                  else if (ras_ok)                        issue = I_PR;
                  else                                    state_d = S_PRE;
               end
            end
         end
         S_PRE:  if (ras_ok) issue = I_PR;
         S_PREA: if (ras_ok) issue = I_PRA;
         S_WAIT: begin
            if (wait_cnt_q == 8'd0) begin
               case (ret_q)
                  S_ACT:   issue = I_ACT;
                  S_RW:    issue = I_RW;
                  S_REF:   issue = I_REF;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (issue)
         I_PR: begin
            commands_d[7] = 1'b1;
            bg_d          = lat_bg_d;
            ba_d          = lat_ba_d;
            open_d[bidx]  = 1'b0;
            wait_cnt_d    = W_RP;
            ret_d         = S_ACT;
            state_d       = S_WAIT;
         end
         I_ACT: begin
            commands_d[18]   = 1'b1;
            bg_d             = lat_bg_d;
            ba_d             = lat_ba_d;
            row_d            = lat_row_d;
            open_d[bidx]     = 1'b1;
            open_row_d[bidx] = lat_row_d;
            ras_cnt_d        = RAS_LOAD;
            wait_cnt_d       = W_RCD;
            ret_d            = S_RW;
            state_d          = S_WAIT;
         end
         I_RW: begin
            if (lat_we_d) commands_d[1] = 1'b1;
            else          commands_d[5] = 1'b1;
            bg_d           = lat_bg_d;
            ba_d           = lat_ba_d;
            ack_d[grant_d] = 1'b1;
            wait_cnt_d     = lat_we_d ? W_WREC : W_CCD;
            ret_d          = S_IDLE;
            state_d        = S_WAIT;
         end
         I_PRA: begin
            commands_d[6] = 1'b1;
            bg_d          = '0;
            ba_d          = '0;
            open_d        = '0;
            wait_cnt_d    = W_RP;
            ret_d         = S_REF;
            state_d       = S_WAIT;
         end
         I_REF: begin
            commands_d[3] = 1'b1;
            bg_d          = '0;
            ba_d          = '0;
            ref_pend_d    = 1'b0;
            wait_cnt_d    = W_RFC;
            ret_d         = S_IDLE;
            state_d       = S_WAIT;
         end
         default: ;
      endcase

      // Interval expiry wins over a same-cycle REF clear; overrun only if still pending.
      if (refi_cnt_q == 16'd0) begin
         ref_pend_d = 1'b1;
         if (ref_pend_q && (issue != I_REF)) ref_overrun_d = 1'b1;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         ret_q         <= S_IDLE;
         wait_cnt_q    <= '0;
         ras_cnt_q     <= '0;
         refi_cnt_q    <= REFI_LOAD;
         ref_pend_q    <= 1'b0;
         ref_overrun_q <= 1'b0;
         rr_last_q     <= GW'(NREQ - 1);
         grant_q       <= '0;
         lat_we_q      <= 1'b0;
         lat_bg_q      <= '0;
         lat_ba_q      <= '0;
         lat_row_q     <= '0;
         open_q        <= '0;
         for (int b = 0; b < NBANK; b++) open_row_q[b] <= '0;
         commands_q    <= '0;
         ack_q         <= '0;
         bg_q          <= '0;
         ba_q          <= '0;
         row_q         <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         wait_cnt_q    <= wait_cnt_d;
         ras_cnt_q     <= ras_cnt_d;
         refi_cnt_q    <= refi_cnt_d;
         ref_pend_q    <= ref_pend_d;
         ref_overrun_q <= ref_overrun_d;
         rr_last_q     <= rr_last_d;
         grant_q       <= grant_d;
         lat_we_q      <= lat_we_d;
         lat_bg_q      <= lat_bg_d;
         lat_ba_q      <= lat_ba_d;
         lat_row_q     <= lat_row_d;
         open_q        <= open_d;
         open_row_q    <= open_row_d;
         commands_q    <= commands_d;
         ack_q         <= ack_d;
         bg_q          <= bg_d;
         ba_q          <= ba_d;
         row_q         <= row_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.commands    = commands_q;
   assign bus.req_ack     = ack_q;
   assign bus.bg          = bg_q;
   assign bus.ba          = ba_q;
   assign bus.row         = row_q;
   assign bus.busy        = busy_q;
   assign bus.ref_overrun = ref_overrun_q;
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Bench for ddr_cmd_sequencer: default-parameter instance for command sequencing,
// arbitration and refresh; a second instance with a short refresh interval and a
// long refresh time for overrun and reset-mid-wait behaviour.
module tb_ddr_cmd_sequencer;
   localparam logic [18:0] C_ACT = 19'h40000;
   localparam logic [18:0] C_PR  = 19'h00080;
   localparam logic [18:0] C_PRA = 19'h00040;
   localparam logic [18:0] C_RD  = 19'h00020;
   localparam logic [18:0] C_REF = 19'h00008;
   localparam logic [18:0] C_WR  = 19'h00002;

   logic clk;
   logic reset_n, reset_n2;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      logic [18:0] cmd;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [15:0] row;
      logic [1:0]  ack;
      int          at;
   } exp_t;
   exp_t sb[$];

   ddr_cmd_sequencer_if #(.NREQ(2), .BGWIDTH(2), .BAWIDTH(2), .ROWWIDTH(16)) ifc ();
   ddr_cmd_sequencer_if #(.NREQ(2), .BGWIDTH(2), .BAWIDTH(2), .ROWWIDTH(16)) ifc2 ();

   ddr_cmd_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
   ddr_cmd_sequencer #(.T_REFI(64), .T_RFC(200)) dut2 (.clk(clk), .reset_n(reset_n2), .bus(ifc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [18:0] cmd, input logic [1:0] bg, input logic [1:0] ba,
                       input logic [15:0] row, input logic [1:0] ack, input int at);
      exp_t e;
      e.cmd = cmd; e.bg = bg; e.ba = ba; e.row = row; e.ack = ack; e.at = at;
      sb.push_back(e);
   endtask

   // Wait for the next command pulse on the main instance and compare it to the queue head.
   task automatic pop_check(input string tag, output int seen);
      exp_t e;
      int   n;
      seen = -1;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n = 0;
         while (n < 12000 && seen < 0) begin
            @(negedge clk);
            if (ifc.commands !== 19'd0) seen = cyc;
            n++;
         end
         chk({tag, "_seen"}, 32'(seen >= 0), 32'd1);
         if (seen >= 0) begin
            chk({tag, "_cmd"}, 32'(ifc.commands), 32'(e.cmd));
            chk({tag, "_bg"},  32'(ifc.bg), 32'(e.bg));
            chk({tag, "_ba"},  32'(ifc.ba), 32'(e.ba));
            chk({tag, "_row"}, 32'(ifc.row), 32'(e.row));
            chk({tag, "_ack"}, 32'(ifc.req_ack), 32'(e.ack));
            chk({tag, "_cyc"}, 32'(seen), 32'(e.at));
         end
      end
   endtask

   task automatic drive_req(input int i, input logic v, input logic we, input logic [1:0] bg,
                            input logic [1:0] ba, input logic [15:0] row);
      ifc.req_valid[i]          = v;
      ifc.req_we[i]             = we;
      ifc.req_bg[i*2 +: 2]      = bg;
      ifc.req_ba[i*2 +: 2]      = ba;
      ifc.req_row[i*16 +: 16]   = row;
   endtask

   initial begin
      int r0, r1, r2, r3, c, w, p, rf, r2base;

      reset_n  = 1'b0;
      reset_n2 = 1'b0;
      ifc.req_valid = '0;  ifc.req_we = '0;  ifc.req_bg = '0;  ifc.req_ba = '0;  ifc.req_row = '0;
      ifc2.req_valid = '0; ifc2.req_we = '0; ifc2.req_bg = '0; ifc2.req_ba = '0; ifc2.req_row = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      r0 = cyc;

      // Reset values
      chk("rst_cmd",  32'(ifc.commands), 32'd0);
      chk("rst_bg",   32'(ifc.bg), 32'd0);
      chk("rst_ba",   32'(ifc.ba), 32'd0);
      chk("rst_row",  32'(ifc.row), 32'd0);
      chk("rst_ack",  32'(ifc.req_ack), 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_ovr",  32'(ifc.ref_overrun), 32'd0);

      // 1: read to closed bank -> ACT n+1, RD n+18
      @(negedge clk);
      c = cyc;
      drive_req(0, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0123);
      push(C_ACT, 2'd1, 2'd2, 16'h0123, 2'b00, c + 1);
      push(C_RD,  2'd1, 2'd2, 16'h0123, 2'b01, c + 18);
      pop_check("t1_act", p);
      chk("t1_busy", 32'(ifc.busy), 32'd1);
      pop_check("t1_rd", r1);

      // 2: same bank/row again -> RD only, one cycle after IDLE re-entry
      push(C_RD, 2'd1, 2'd2, 16'h0123, 2'b01, r1 + 4 + 1);
      pop_check("t2_rd", r2);

      // 3: row conflict -> PR no earlier than tRAS after ACT, then ACT, then RD
      drive_req(0, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0456);
      push(C_PR,  2'd1, 2'd2, 16'h0123, 2'b00, p + 32);
      push(C_ACT, 2'd1, 2'd2, 16'h0456, 2'b00, p + 32 + 17);
      push(C_RD,  2'd1, 2'd2, 16'h0456, 2'b01, p + 32 + 34);
      pop_check("t3_pr", p);
      pop_check("t3_act", p);
      pop_check("t3_rd", r3);

      // 4: both requesters valid -> alternating grants; req1 writes to a closed bank
      drive_req(1, 1'b1, 1'b1, 2'd2, 2'd1, 16'h0789);
      push(C_ACT, 2'd2, 2'd1, 16'h0789, 2'b00, r3 + 5);
      push(C_WR,  2'd2, 2'd1, 16'h0789, 2'b10, r3 + 22);
      push(C_RD,  2'd1, 2'd2, 16'h0789, 2'b01, r3 + 51);
      push(C_WR,  2'd2, 2'd1, 16'h0789, 2'b10, r3 + 56);
      push(C_RD,  2'd1, 2'd2, 16'h0789, 2'b01, r3 + 85);
      pop_check("t4_act", p);
      pop_check("t4_wr1", p);
      pop_check("t4_rd0", p);
      pop_check("t4_wr1b", p);
      pop_check("t4_rd0b", p);
      ifc.req_valid[0] = 1'b0;
      push(C_WR, 2'd2, 2'd1, 16'h0789, 2'b10, r3 + 90);
      pop_check("t4_req1_alone", w);
      // WR recovery: next request served T_CWL+BL/2+T_WR+1 after the WR
      ifc.req_valid[1] = 1'b0;
      drive_req(0, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0456);
      push(C_RD, 2'd1, 2'd2, 16'h0789, 2'b01, w + 29);
      pop_check("t4_after_wr", p);
      ifc.req_valid[0] = 1'b0;

      // 5: refresh at interval expiry with banks open -> PRA, REF +17, next cmd +35
      push(C_PRA, 2'd0, 2'd0, 16'h0789, 2'b00, r0 + 9361);
      push(C_REF, 2'd0, 2'd0, 16'h0789, 2'b00, r0 + 9378);
      pop_check("t5_pra", p);
      pop_check("t5_ref", rf);
      drive_req(0, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0456);
      push(C_ACT, 2'd1, 2'd2, 16'h0456, 2'b00, rf + 35);
      push(C_RD,  2'd1, 2'd2, 16'h0456, 2'b01, rf + 52);
      pop_check("t5_act", p);
      pop_check("t5_rd", p);
      ifc.req_valid[0] = 1'b0;
      chk("t5_ovr", 32'(ifc.ref_overrun), 32'd0);

      // 6: short-interval instance kept busy by a long refresh -> overrun, then reset mid-WAIT
      @(negedge clk);
      reset_n2 = 1'b1;
      r2base = cyc;
      while (cyc < r2base + 65) @(negedge clk);
      chk("t6_ref", 32'(ifc2.commands), 32'(C_REF));
      while (cyc < r2base + 150) @(negedge clk);
      chk("t6_busy_a", 32'(ifc2.busy), 32'd1);
      chk("t6_ovr_a",  32'(ifc2.ref_overrun), 32'd0);
      while (cyc < r2base + 250) @(negedge clk);
      chk("t6_busy_b", 32'(ifc2.busy), 32'd1);
      chk("t6_ovr_b",  32'(ifc2.ref_overrun), 32'd1);
      reset_n2 = 1'b0;
      @(negedge clk);
      chk("t6_rst_cmd",  32'(ifc2.commands), 32'd0);
      chk("t6_rst_bg",   32'(ifc2.bg), 32'd0);
      chk("t6_rst_ba",   32'(ifc2.ba), 32'd0);
      chk("t6_rst_row",  32'(ifc2.row), 32'd0);
      chk("t6_rst_ack",  32'(ifc2.req_ack), 32'd0);
      chk("t6_rst_busy", 32'(ifc2.busy), 32'd0);
      chk("t6_rst_ovr",  32'(ifc2.ref_overrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
